// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing source for the VGA path. A free-running pixel counter,
//   qualified by pixelEn, produces the raster position, the active-low syncs,
//   the visible-region flag and a one-clock start-of-frame pulse. Every output
//   is a register. The syncs and blanking are derived from the next count, so
//   they change on the same edge as pixelX/pixelY.
//
//   Optional build: define VGA_FRAME_COUNT_EN to add an 8-bit frame counter
//   output (frameCount) that increments on each start of frame.
//
// Ports
//   clk           in   system clock
//   resetN        in   asynchronous active-low reset
//   pixelEn       in   pixel tick; counters advance only when 1
//   pixelX        out  horizontal count, 0..H_TOTAL-1
//   pixelY        out  vertical count, 0..V_TOTAL-1
//   hsync         out  active-low horizontal sync
//   vsync         out  active-low vertical sync
//   blankN        out  1 inside the visible region
//   startOfFrame  out  one-clock pulse when the counters enter (0,0)
//   frameCount    out  frame counter (VGA_FRAME_COUNT_EN builds only)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        pixelEn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        hsync,
  output logic        vsync,
  output logic        blankN,
  output logic        startOfFrame
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0]  frameCount
`endif
);

  localparam logic [10:0] H_TOTAL   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] V_TOTAL   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_LO = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_LO = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_HI = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank_n;
  logic        r_sof;

  logic [10:0] w_x_next;
  logic [10:0] w_y_next;
  logic        w_x_wrap;
  logic        w_y_wrap;
  logic        w_sof;

  // Advance values; only consumed on cycles with pixelEn=1.
  always_comb begin
    w_x_wrap = (r_x == H_TOTAL - 11'd1);
    w_y_wrap = (r_y == V_TOTAL - 11'd1);
    w_x_next = w_x_wrap ? 11'd0 : r_x + 11'd1;
    w_y_next = r_y;
    if (w_x_wrap) begin
      w_y_next = w_y_wrap ? 11'd0 : r_y + 11'd1;
    end
    w_sof = (w_x_next == 11'd0) && (w_y_next == 11'd0);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_x       <= H_TOTAL - 11'd1;
      r_y       <= V_TOTAL - 11'd1;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_blank_n <= 1'b0;
      r_sof     <= 1'b0;
    end else begin
      // The pulse drops on any cycle without a pixel tick, so it never stretches.
      r_sof <= 1'b0;
      if (pixelEn) begin
        r_x       <= w_x_next;
        r_y       <= w_y_next;
        r_hsync   <= !((w_x_next >= H_SYNC_LO) && (w_x_next < H_SYNC_HI));
        r_vsync   <= !((w_y_next >= V_SYNC_LO) && (w_y_next < V_SYNC_HI));
        r_blank_n <= (w_x_next < H_ACT) && (w_y_next < V_ACT);
        r_sof     <= w_sof;
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] r_frame_cnt;

  // The frame entered on reset exit counts as frame 1.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_frame_cnt <= 8'd0;
    end else if (pixelEn && w_sof) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frameCount = r_frame_cnt;
`endif

  assign pixelX       = r_x;
  assign pixelY       = r_y;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign blankN       = r_blank_n;
  assign startOfFrame = r_sof;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances share clock, reset and pixelEn: u_d uses the standard
//   640x480 timing, u_s a tiny 10x8 raster (H 4/2/2/2, V 3/1/2/2) so that
//   whole frames, frame period and frame-counter wrap fit in a short run.
//   Expected values are hand-computed and queued with the absolute clock
//   tick at which they must be visible; a monitor samples on each falling
//   edge and compares every entry due at that tick.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk;
  logic resetN;
  logic pixelEn;

  logic [10:0] d_x, d_y, s_x, s_y;
  logic        d_hs, d_vs, d_bn, d_sof;
  logic        s_hs, s_vs, s_bn, s_sof;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0]  d_fc, s_fc;
`endif

  vga_timing_gen u_d (
    .clk          (clk),
    .resetN       (resetN),
    .pixelEn      (pixelEn),
    .pixelX       (d_x),
    .pixelY       (d_y),
    .hsync        (d_hs),
    .vsync        (d_vs),
    .blankN       (d_bn),
    .startOfFrame (d_sof)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frameCount   (d_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_s (
    .clk          (clk),
    .resetN       (resetN),
    .pixelEn      (pixelEn),
    .pixelX       (s_x),
    .pixelY       (s_y),
    .hsync        (s_hs),
    .vsync        (s_vs),
    .blankN       (s_bn),
    .startOfFrame (s_sof)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frameCount   (s_fc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  typedef struct {
    string       nm;
    int          at;
    bit          inst;     // 0 = u_d, 1 = u_s
    bit          chk_fc;
    logic [10:0] x;
    logic [10:0] y;
    logic        hs;
    logic        vs;
    logic        bn;
    logic        sof;
    logic [7:0]  fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string nm, input int at, input bit inst,
                      input int x, input int y,
                      input bit hs, input bit vs, input bit bn, input bit sof);
    exp_t e;
    e.nm = nm; e.at = at; e.inst = inst; e.chk_fc = 1'b0;
    e.x = 11'(x); e.y = 11'(y);
    e.hs = hs; e.vs = vs; e.bn = bn; e.sof = sof; e.fc = 8'd0;
    sb.push_back(e);
  endtask

`ifdef VGA_FRAME_COUNT_EN
  task automatic push_fc(input string nm, input int at, input bit inst, input int fc);
    exp_t e;
    e.nm = nm; e.at = at; e.inst = inst; e.chk_fc = 1'b1;
    e.x = '0; e.y = '0; e.hs = 1'b0; e.vs = 1'b0; e.bn = 1'b0; e.sof = 1'b0;
    e.fc = 8'(fc);
    sb.push_back(e);
  endtask
`endif

  task automatic check_entry(input exp_t e);
    logic [10:0] ax, ay;
    logic        ahs, avs, abn, asof;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0]  afc;
    afc = e.inst ? s_fc : d_fc;
`endif
    ax   = e.inst ? s_x   : d_x;
    ay   = e.inst ? s_y   : d_y;
    ahs  = e.inst ? s_hs  : d_hs;
    avs  = e.inst ? s_vs  : d_vs;
    abn  = e.inst ? s_bn  : d_bn;
    asof = e.inst ? s_sof : d_sof;
    checks++;
    if (e.chk_fc) begin
`ifdef VGA_FRAME_COUNT_EN
      if (afc !== e.fc) begin
        errors++;
        $display("FAIL %s tick=%0d frameCount got %0d expected %0d", e.nm, tick, afc, e.fc);
      end
`endif
    end else if ({ax, ay, ahs, avs, abn, asof} !== {e.x, e.y, e.hs, e.vs, e.bn, e.sof}) begin
      errors++;
      $display("FAIL %s tick=%0d got x=%0d y=%0d hs=%0b vs=%0b bn=%0b sof=%0b expected x=%0d y=%0d hs=%0b vs=%0b bn=%0b sof=%0b",
               e.nm, tick, ax, ay, ahs, avs, abn, asof, e.x, e.y, e.hs, e.vs, e.bn, e.sof);
    end
  endtask

  // Monitor: compare every queued expectation due at the current tick.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at == tick) begin
          check_entry(sb[i]);
          sb.delete(i);
        end else if (sb[i].at < tick) begin
          checks++;
          errors++;
          $display("FAIL %s missed: due tick %0d, now %0d", sb[i].nm, sb[i].at, tick);
          sb.delete(i);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int base;
  int b;

  initial begin
    resetN  = 1'b0;
    pixelEn = 1'b0;

    // Reset values.
    push("rst_d", 2, 0, 799, 524, 1, 1, 0, 0);
    push("rst_s", 2, 1,   9,   7, 1, 1, 0, 0);
`ifdef VGA_FRAME_COUNT_EN
    push_fc("rst_fc", 2, 0, 0);
`endif
    step(3);
    base    = tick;
    resetN  = 1'b1;
    pixelEn = 1'b1;

    // Continuous pixelEn, standard timing: first line.
    push("d_sof_first", base + 1,    0,   0, 0, 1, 1, 1, 1);
    push("d_sof_clear", base + 2,    0,   1, 0, 1, 1, 1, 0);
    push("d_x639",      base + 640,  0, 639, 0, 1, 1, 1, 0);
    push("d_x640_blank",base + 641,  0, 640, 0, 1, 1, 0, 0);
    push("d_x655",      base + 656,  0, 655, 0, 1, 1, 0, 0);
    push("d_hs_fall",   base + 657,  0, 656, 0, 0, 1, 0, 0);
    push("d_x751",      base + 752,  0, 751, 0, 0, 1, 0, 0);
    push("d_hs_rise",   base + 753,  0, 752, 0, 1, 1, 0, 0);
    push("d_x799",      base + 800,  0, 799, 0, 1, 1, 0, 0);
    push("d_line_wrap", base + 801,  0,   0, 1, 1, 1, 1, 0);
    push("d_x699",      base + 1500, 0, 699, 1, 0, 1, 0, 0);
`ifdef VGA_FRAME_COUNT_EN
    push_fc("d_fc_first", base + 1, 0, 1);
`endif

    // Continuous pixelEn, tiny raster: line and frame boundaries.
    push("s_sof_first", base + 1,  1, 0, 0, 1, 1, 1, 1);
    push("s_x3",        base + 4,  1, 3, 0, 1, 1, 1, 0);
    push("s_x4_blank",  base + 5,  1, 4, 0, 1, 1, 0, 0);
    push("s_hs_fall",   base + 7,  1, 6, 0, 0, 1, 0, 0);
    push("s_hs_low",    base + 8,  1, 7, 0, 0, 1, 0, 0);
    push("s_hs_rise",   base + 9,  1, 8, 0, 1, 1, 0, 0);
    push("s_x9",        base + 10, 1, 9, 0, 1, 1, 0, 0);
    push("s_line_wrap", base + 11, 1, 0, 1, 1, 1, 1, 0);
    push("s_y3_blank",  base + 31, 1, 0, 3, 1, 1, 0, 0);
    push("s_y3_end",    base + 40, 1, 9, 3, 1, 1, 0, 0);
    push("s_vs_fall",   base + 41, 1, 0, 4, 1, 0, 0, 0);
    push("s_vs_last",   base + 60, 1, 9, 5, 1, 0, 0, 0);
    push("s_vs_rise",   base + 61, 1, 0, 6, 1, 1, 0, 0);
    push("s_frame_end", base + 80, 1, 9, 7, 1, 1, 0, 0);
    push("s_sof_2nd",   base + 81, 1, 0, 0, 1, 1, 1, 1);
    push("s_sof_2clr",  base + 82, 1, 1, 0, 1, 1, 1, 0);
    push("s_k1500",     base + 1500, 1, 9, 5, 1, 0, 0, 0);
`ifdef VGA_FRAME_COUNT_EN
    push_fc("s_fc_2nd", base + 81, 1, 2);
`endif

    // Reset asserted right after the edge that makes X=700 (hsync low);
    // the falling-edge sample sees reset values with no clock edge between.
    push("d_rst_async", base + 1501, 0, 799, 524, 1, 1, 0, 0);
    push("s_rst_async", base + 1501, 1,   9,   7, 1, 1, 0, 0);
    push("d_rst_held",  base + 1502, 0, 799, 524, 1, 1, 0, 0);
    push("d_rst_exit",  base + 1503, 0,   0,   0, 1, 1, 1, 1);
    push("s_rst_exit",  base + 1503, 1,   0,   0, 1, 1, 1, 1);
    push("d_rst_exit2", base + 1504, 0,   1,   0, 1, 1, 1, 0);
    push("s_rst_exit2", base + 1504, 1,   1,   0, 1, 1, 1, 0);
    push("d_rst_again", base + 1505, 0, 799, 524, 1, 1, 0, 0);
`ifdef VGA_FRAME_COUNT_EN
    push_fc("d_fc_rst",  base + 1501, 0, 0);
    push_fc("d_fc_exit", base + 1503, 0, 1);
`endif

    step(1501);
    resetN = 1'b0;
    step(1);
    resetN = 1'b1;
    step(3);
    resetN  = 1'b0;
    pixelEn = 1'b0;
    step(1);
    b       = tick;
    resetN  = 1'b1;
    pixelEn = 1'b1;

    // pixelEn toggles 1/0: counters advance on edges b+1, b+3, ...
    push("d_tg_sof",    b + 1,    0,   0, 0, 1, 1, 1, 1);
    push("d_tg_hold",   b + 2,    0,   0, 0, 1, 1, 1, 0);
    push("d_tg_step",   b + 3,    0,   1, 0, 1, 1, 1, 0);
    push("d_tg_x655",   b + 1312, 0, 655, 0, 1, 1, 0, 0);
    push("d_tg_hsfall", b + 1313, 0, 656, 0, 0, 1, 0, 0);
    push("s_tg_sof",    b + 1,    1,   0, 0, 1, 1, 1, 1);
    push("s_tg_hold",   b + 2,    1,   0, 0, 1, 1, 1, 0);
    push("s_tg_step",   b + 3,    1,   1, 0, 1, 1, 1, 0);
    push("s_tg_end",    b + 160,  1,   9, 7, 1, 1, 0, 0);
    push("s_tg_sof2",   b + 161,  1,   0, 0, 1, 1, 1, 1);
    push("s_tg_sof2h",  b + 162,  1,   0, 0, 1, 1, 1, 0);
    push("s_tg_sof257", b + 160*256 + 1, 1, 0, 0, 1, 1, 1, 1);
    push("s_tg_sof257h",b + 160*256 + 2, 1, 0, 0, 1, 1, 1, 0);
`ifdef VGA_FRAME_COUNT_EN
    push_fc("d_fc_tg1",    b + 2,               0, 1);
    push_fc("s_fc_tg1",    b + 2,               1, 1);
    push_fc("s_fc_tg2",    b + 162,             1, 2);
    push_fc("s_fc_255",    b + 160*255,         1, 255);
    push_fc("s_fc_wrap0",  b + 160*255 + 2,     1, 0);
    push_fc("s_fc_wrap1",  b + 160*256 + 2,     1, 1);
`endif

    while (tick < b + 160*256 + 4) begin
      step(1);
      pixelEn = ((tick - b) % 2 == 0);
    end

    step(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending entries got %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
